// File: rtl/fuse_key_loader.sv
// Fuse key loader: reads 1..8 fuse words into a 256-bit key; FUSE_LOADER_VERIFY_EN adds a compare re-read pass.
// Latency start->done len+2 cycles (2*len+3 with verify, 1 for illegal len); no backpressure, start ignored while busy.
module fuse_key_loader #(
  parameter int MAX_WORDS = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [31:0]             base_addr_i,
  input  logic [3:0]              len_i,
  output logic                    fuse_req_o,
  output logic [31:0]             fuse_addr_o,
  input  logic [31:0]             fuse_rdata_i,
  output logic [32*MAX_WORDS-1:0] key_o,
  output logic                    key_valid_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int KW = 32 * MAX_WORDS;
  localparam int IW = $clog2(MAX_WORDS);
  localparam int BW = IW + 5;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
`ifdef FUSE_LOADER_VERIFY_EN
  localparam logic [2:0] S_VERIFY = 3'd3;
`endif
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [31:0]   base_q, base_d;
  logic [3:0]    len_q, len_d;
  logic [IW-1:0] req_idx_q, req_idx_d;
  logic          fuse_req_q, fuse_req_d;
  logic [31:0]   fuse_addr_q, fuse_addr_d;
  logic [KW-1:0] key_q, key_d;
  logic          key_valid_q, key_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          cap_vld_q, cap_vld_d;
  logic [IW-1:0] cap_idx_q, cap_idx_d;
`ifdef FUSE_LOADER_VERIFY_EN
  logic          cap_cmp_q, cap_cmp_d;
  logic          mis_q, mis_d;
`endif

  logic          len_ok;
  logic          last_req;
  logic [IW-1:0] req_nxt;
  logic [BW-1:0] cap_bit;

  assign len_ok   = (len_i != 4'd0) && (len_i <= 4'(MAX_WORDS));
  assign last_req = (4'(req_idx_q) == (len_q - 4'd1));
  assign req_nxt  = req_idx_q + IW'(1);
  assign cap_bit  = {cap_idx_q, 5'd0};

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    req_idx_d   = req_idx_q;
    fuse_req_d  = fuse_req_q;
    fuse_addr_d = fuse_addr_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    // Read data returns one cycle after its request; track which word it is.
    cap_vld_d   = fuse_req_q;
    cap_idx_d   = req_idx_q;
`ifdef FUSE_LOADER_VERIFY_EN
    cap_cmp_d   = (state_q == S_VERIFY);
    mis_d       = mis_q;
    if (cap_vld_q && cap_cmp_q) begin
      if (key_q[cap_bit +: 32] != fuse_rdata_i) begin
        mis_d = 1'b1;
      end
    end else if (cap_vld_q) begin
      key_d[cap_bit +: 32] = fuse_rdata_i;
    end
`else
    if (cap_vld_q) begin
      key_d[cap_bit +: 32] = fuse_rdata_i;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          base_d      = base_addr_i;
          len_d       = len_i;
          req_idx_d   = '0;
          key_d       = '0;
          key_valid_d = 1'b0;
          err_d       = 1'b0;
          busy_d      = 1'b1;
`ifdef FUSE_LOADER_VERIFY_EN
          mis_d       = 1'b0;
`endif
          if (len_ok) begin
            state_d     = S_READ;
            fuse_req_d  = 1'b1;
            fuse_addr_d = base_addr_i;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end

      S_READ: begin
        if (last_req) begin
          fuse_req_d = 1'b0;
          state_d    = S_DRAIN;
        end else begin
          req_idx_d   = req_nxt;
          fuse_addr_d = base_q + 32'(req_nxt);
        end
      end

      S_DRAIN: begin
`ifdef FUSE_LOADER_VERIFY_EN
        state_d     = S_VERIFY;
        fuse_req_d  = 1'b1;
        req_idx_d   = '0;
        fuse_addr_d = base_q;
`else
        state_d     = S_DONE;
        done_d      = 1'b1;
        key_valid_d = 1'b1;
`endif
      end

`ifdef FUSE_LOADER_VERIFY_EN
      S_VERIFY: begin
        if (fuse_req_q) begin
          if (last_req) begin
            fuse_req_d = 1'b0;
          end else begin
            req_idx_d   = req_nxt;
            fuse_addr_d = base_q + 32'(req_nxt);
          end
        end else begin
          // Drain cycle: mis_d already includes the final word's compare.
          state_d = S_DONE;
          done_d  = 1'b1;
          if (mis_d) begin
            err_d = 1'b1;
            key_d = '0;
          end else begin
            key_valid_d = 1'b1;
          end
        end
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      req_idx_q   <= '0;
      fuse_req_q  <= 1'b0;
      fuse_addr_q <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cap_vld_q   <= 1'b0;
      cap_idx_q   <= '0;
`ifdef FUSE_LOADER_VERIFY_EN
      cap_cmp_q   <= 1'b0;
      mis_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      req_idx_q   <= req_idx_d;
      fuse_req_q  <= fuse_req_d;
      fuse_addr_q <= fuse_addr_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cap_vld_q   <= cap_vld_d;
      cap_idx_q   <= cap_idx_d;
`ifdef FUSE_LOADER_VERIFY_EN
      cap_cmp_q   <= cap_cmp_d;
      mis_q       <= mis_d;
`endif
    end
  end

  assign fuse_req_o  = fuse_req_q;
  assign fuse_addr_o = fuse_addr_q;
  assign key_o       = key_q;
  assign key_valid_o = key_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: doc/fuse_key_loader.md
# fuse_key_loader

Sequential reader that sits directly downstream of the fuse memory. It drives the fuse memory's request/address port, collects 1–8 consecutive 32-bit fuse words into a 256-bit key register and presents it to a crypto engine (AES/SHA/HMAC key input) with a valid flag. It replaces hard-wired key taps with a software-triggered, optionally double-read-verified load.

## Interface
Parameters:
- `MAX_WORDS`, default 8: maximum words per load. Fixed at 8 in this revision; `key_o` width is `32*MAX_WORDS`.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  load request; sampled only in IDLE.
- `base_addr_i`  in  32  fuse word address of word 0; sampled with `start_i`.
- `len_i`  in  4  number of words, 1..8; sampled with `start_i`.
- `fuse_req_o`  out  1  read request to fuse memory.
- `fuse_addr_o`  out  32  fuse word address.
- `fuse_rdata_i`  in  32  fuse data, valid the cycle after `fuse_req_o`/`fuse_addr_o`.
- `key_o`  out  256  assembled key.
- `key_valid_o`  out  1  `key_o` holds a completed, verified load.
- `busy_o`  out  1  load in progress.
- `done_o`  out  1  one-cycle pulse at load completion, success or error.
- `err_o`  out  1  sticky error for the last load.

## Operation
- States: IDLE, READ, DRAIN, VERIFY (only when the macro is defined), DONE.
- IDLE: if `start_i`, latch base/len, clear `key_o`, `key_valid_o` and `err_o`, set word counter to 0, go to READ.
  - `len_i` of 0 or >8 is illegal: go to DONE with `err_o`=1 and no fuse reads.
- READ: `fuse_req_o`=1, `fuse_addr_o`=base+counter (32-bit modulo, wraps silently). One request per cycle.
  - Each cycle after a request, capture `fuse_rdata_i` into `key_o[32*i +: 32]` for word i. Word at base+i lands at bit 32*i, so the highest address is the MSBs.
  - After request len-1, go to DRAIN.
- DRAIN: `fuse_req_o`=0; capture the last word. Then go to VERIFY if `FUSE_LOADER_VERIFY_EN` is defined, else DONE.
- VERIFY: re-issues the same len reads with the same pipelining and compares each returned word with the stored word. Any mismatch sets a mismatch flag. After the final compare (one drain cycle), go to DONE.
- DONE: `done_o`=1 for this cycle, then go to IDLE.
  - Success: `key_valid_o`=1.
  - Error (illegal len or mismatch): `err_o`=1, `key_o` forced to 0, `key_valid_o` stays 0.
- Words above len-1 read as 0 in `key_o`.
- `start_i` outside IDLE (including in DONE) is ignored; it is not queued.
- `start_i` in IDLE while `key_valid_o`=1 starts a reload. `key_valid_o` drops the cycle after acceptance.
- `busy_o`=1 in READ, DRAIN, VERIFY and DONE.
- Reset mid-operation aborts immediately; all outputs take their reset values.

## Timing
- Reset values: `fuse_req_o`=0, `fuse_addr_o`=0, `key_o`=0, `key_valid_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0; state IDLE.
- `start_i` accepted at edge T0. First `fuse_req_o` is high in cycle T0+1.
- Without verify: `done_o` is high in cycle T0+len+2, together with `key_valid_o` rising. len=8 → `done_o` in cycle T0+10.
- With verify: `done_o` in cycle T0+2*len+3.
- Illegal len: `done_o`/`err_o` in cycle T0+1, and `fuse_req_o` never asserts.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `FUSE_LOADER_VERIFY_EN` defined: VERIFY state is compiled in. Every word is read twice and the load fails on any mismatch, covering glitch or fault-injection disturbance of the fuse read path.
- Not defined: VERIFY logic and the compare register are absent. A load completes after a single pass and `err_o` only reports an illegal len.

## Test plan
- Fuse model returns `addr*32'h01010101`. Start with base=73, len=8 → 8 consecutive requests to addresses 73..80; `key_o[31:0]`=0x49494949, `key_o[255:224]`=0x50505050; `key_valid_o`=1, `done_o` at T0+10 (non-verify build).
- len=3, base=0xFFFFFFFF → addresses 0xFFFFFFFF, 0x0, 0x1; `key_o[255:96]`=0; `key_valid_o`=1.
- len=0 and len=9 → `done_o` at T0+1, `err_o`=1, `key_valid_o`=0, zero fuse requests.
- Verify build: fuse model flips bit 0 of address 75 on the second read, with base=73, len=8 → `err_o`=1, `key_o`=0, `key_valid_o`=0 at T0+19. Same run without the fault → `key_valid_o`=1.
- Pulse `start_i` every cycle during a load → exactly one load executes. After `done_o`, a new start reloads and `key_valid_o` drops the cycle after acceptance.
- Assert `rst_ni`=0 asynchronously during READ word 4 → all outputs zero immediately. After release, a fresh len=2 load completes correctly.
